mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 114 +++++++++++
 tb/tb_mul_div_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiplier / restoring divider.
//   A multiply is shift-and-add and a divide is restoring division. Both run
//   one bit per cycle for WIDTH cycles on a shared (2*WIDTH+1)-bit register.
//   A divide by zero skips the iterations and finishes one cycle after accept.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start, op         request pulse; op 0 = multiply, 1 = divide
//   operand_a/b       multiplicand/dividend, multiplier/divisor
//   busy              high in RUN and DONE
//   done              one-cycle pulse when result is final
//   div_by_zero       last accepted operation was a divide by zero
//   result            product, or {remainder, quotient}
module mul_div_unit #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [2*WIDTH:0] acc;      // upper WIDTH+1 bits: partial sum / remainder
    logic [WIDTH-1:0] divisor;  // captured operand_b (multiplier or divisor)
    logic             op_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   upper;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] mul_next;
    logic [2*WIDTH:0] div_sh;
    logic [WIDTH+1:0] div_diff;
    logic [2*WIDTH:0] div_next;
    logic [2*WIDTH:0] run_next;

    always_comb begin
        upper    = acc[2*WIDTH:WIDTH];
        // Upper part stays below 2^WIDTH after each shift, so the W+1-bit
        // sum never overflows.
        mul_sum  = acc[0] ? (upper + {1'b0, divisor}) : upper;
        mul_next = {1'b0, mul_sum, acc[WIDTH-1:1]};

        div_sh   = {acc[2*WIDTH-1:0], 1'b0};
        // One extra bit on the difference acts as the borrow/sign.
        div_diff = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b00, divisor};
        div_next = div_diff[WIDTH+1] ? div_sh
                                     : {div_diff[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};

        run_next = op_q ? div_next : mul_next;
    end

    assign result = acc[2*WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            divisor     <= '0;
            op_q        <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        divisor <= operand_b;
                        busy    <= 1'b1;
                        if (op && operand_b == '0) begin
                            acc         <= {1'b0, operand_a, {WIDTH{1'b1}}};
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            acc         <= {{(WIDTH+1){1'b0}}, operand_a};
                            cnt         <= CW'(WIDTH);
                            div_by_zero <= 1'b0;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= run_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit at WIDTH=8: the driver pushes the
// arithmetic expectation at each accepting edge, a negedge monitor pops and
// compares on every done pulse.
module tb_mul_div_unit;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic           dbz;
    logic [2*W-1:0] result;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(a), .operand_b(b),
        .busy(busy), .done(done), .div_by_zero(dbz), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic        dz;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t last;
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic exp_t model(input logic o, input logic [7:0] x, input logic [7:0] y, input int c);
        exp_t e;
        e.acc_cyc = c;
        if (!o) begin
            e.res = 16'(int'(x) * int'(y));
            e.dz  = 1'b0;
            e.lat = W + 1;
        end else if (y == 8'd0) begin
            e.res = {x, 8'hFF};
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            e.res = {8'(x % y), 8'(x / y)};
            e.dz  = 1'b0;
            e.lat = W + 1;
        end
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (reset && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                last  = mon_e;
                chk("result", {16'd0, result}, {16'd0, mon_e.res});
                chk("div_by_zero", {31'd0, dbz}, {31'd0, mon_e.dz});
                chk("latency", cyc - mon_e.acc_cyc + 1, mon_e.lat);
                chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 40);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y);
        wait_idle();
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        sbq.push_back(model(o, x, y, cyc));
        start = 1'b0;
    endtask

    task automatic issue_and_hold(input logic o, input logic [7:0] x, input logic [7:0] y);
        issue(o, x, y);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("hold_result", {16'd0, result}, {16'd0, last.res});
        chk("hold_dbz", {31'd0, dbz}, {31'd0, last.dz});
    endtask

    initial begin
        int t;
        reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_dbz", {31'd0, dbz}, 32'd0);
        chk("reset_result", {16'd0, result}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed vectors
        issue_and_hold(1'b0, 8'd13, 8'd11);
        issue_and_hold(1'b0, 8'd255, 8'd255);
        issue_and_hold(1'b1, 8'd100, 8'd7);
        issue_and_hold(1'b1, 8'd37, 8'd0);
        issue_and_hold(1'b0, 8'd2, 8'd3);
        issue_and_hold(1'b1, 8'd3, 8'd200);
        issue_and_hold(1'b1, 8'd255, 8'd1);

        // Start during RUN with different operands is ignored
        issue(1'b0, 8'd13, 8'd11);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 1'b1; a = 8'd99; b = 8'd0;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("run_start_ignored", {31'd0, busy}, 32'd0);
        chk("run_start_result", {16'd0, result}, 32'h008F);

        // Start held through the done cycle: accepted only once back in IDLE
        issue(1'b1, 8'd100, 8'd7);
        start = 1'b1; op = 1'b0; a = 8'd255; b = 8'd255;
        t = 0;
        while (!done && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        chk("done_start_ignored", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("accept_after_done", {31'd0, busy}, 32'd1);
        sbq.push_back(model(1'b0, 8'd255, 8'd255, cyc));
        start = 1'b0;
        wait_idle();

        // Reset in the middle of a multiply
        issue(1'b0, 8'd200, 8'd3);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_result", {16'd0, result}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        chk("midrst_no_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        issue_and_hold(1'b0, 8'd13, 8'd11);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic       ro;
            logic [7:0] ra;
            logic [7:0] rb;
            ro = 1'($urandom);
            ra = 8'($urandom);
            rb = ($urandom % 6 == 0) ? 8'd0 : 8'($urandom);
            issue(ro, ra, rb);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
